// File: rtl/nt_resp_pkg.sv
// Shared defaults and FSM state encoding for the Nt-node response compactor.
package nt_resp_pkg;

    localparam int unsigned SIG_W_DEF = 16;
    localparam logic [15:0] POLY_DEF  = 16'h1021;
    localparam int unsigned CNT_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nt_misr_step.sv
// One serial-input MISR step: shift left, fold the MSB through POLY, inject resp_in at bit 0.
module nt_misr_step #(
    parameter int unsigned     SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             resp_in,
    output logic [SIG_W-1:0] sig_next
);

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-1){1'b0}}, resp_in};
    end

endmodule

// File: rtl/nt_resp_compactor.sv
// Compacts a windowed stream of single-bit node responses into a MISR signature
// and compares it against a golden value at the end of each window.
module nt_resp_compactor
    import nt_resp_pkg::*;
#(
    parameter int unsigned      SIG_W = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter int unsigned      CNT_W = CNT_W_DEF
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [7:0]       win_len,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic             resp_in,
    input  logic             resp_valid,
    output logic [SIG_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic             alarm
);

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_d;
    logic [SIG_W-1:0]   sig_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target;
    logic [7:0]         wl_q, wl_d;
    logic [SIG_W-1:0]   gold_q, gold_d;
    logic               mismatch_d;
    logic               alarm_d;

    nt_misr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr_step (
        .sig      (sig),
        .resp_in  (resp_in),
        .sig_next (sig_step)
    );

    // A latched length of zero selects the full 256-sample window.
    assign target = (wl_q == 8'd0) ? CNT_W'(256) : CNT_W'(wl_q);

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        sig_d      = sig;
        cnt_d      = cnt_q;
        wl_d       = wl_q;
        gold_d     = gold_q;
        mismatch_d = mismatch;
        alarm_d    = alarm;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    state_d    = RUN;
                    wl_d       = win_len;
                    gold_d     = golden_sig;
                    sig_d      = '0;
                    cnt_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == target) begin
                        state_d    = DONE;
                        mismatch_d = (sig_step != gold_q);
                        alarm_d    = alarm | mismatch_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            sig      <= '0;
            cnt_q    <= '0;
            wl_q     <= '0;
            gold_q   <= '0;
            mismatch <= 1'b0;
            alarm    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sig      <= sig_d;
            cnt_q    <= cnt_d;
            wl_q     <= wl_d;
            gold_q   <= gold_d;
            mismatch <= mismatch_d;
            alarm    <= alarm_d;
            busy     <= (state_d == RUN);
            done     <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_nt_resp_compactor.sv
// Directed bench for nt_resp_compactor with a scoreboard of expected window results.
module tb_nt_resp_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  win_len;
    logic [15:0] golden_sig;
    logic        resp_in;
    logic        resp_valid;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic        alarm;

    typedef struct {
        logic [15:0] sig;
        logic        mm;
        logic        al;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    nt_resp_compactor dut (
        .I1470_clk  (clk),
        .I1477_rst  (rst),
        .start      (start),
        .win_len    (win_len),
        .golden_sig (golden_sig),
        .resp_in    (resp_in),
        .resp_valid (resp_valid),
        .sig        (sig),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] misr_m(input logic [15:0] s, input logic r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Open a window and record what its done pulse must report.
    task automatic open(input logic [7:0] wl, input logic [15:0] gold,
                        input logic [15:0] exp_sig, input logic exp_al);
        exp_t e;
        e.sig = exp_sig;
        e.mm  = (exp_sig != gold);
        e.al  = exp_al;
        sb.push_back(e);
        start      = 1'b1;
        win_len    = wl;
        golden_sig = gold;
        tick();
        start = 1'b0;
        chk("open_busy", 32'(busy), 32'd1);
        chk("open_sig", 32'(sig), 32'd0);
        chk("open_mm", 32'(mismatch), 32'd0);
    endtask

    task automatic sample(input logic r, input logic v, input logic last);
        exp_t e;
        resp_in    = r;
        resp_valid = v;
        tick();
        resp_in    = 1'b0;
        resp_valid = 1'b0;
        chk("done", 32'(done), 32'(last));
        if (done) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("final_sig", 32'(sig), 32'(e.sig));
                chk("final_mm", 32'(mismatch), 32'(e.mm));
                chk("final_alarm", 32'(alarm), 32'(e.al));
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic        bits [256];
        logic [15:0] exp_s;

        rst = 1'b1; start = 1'b0; win_len = 8'd0; golden_sig = 16'h0;
        resp_in = 1'b0; resp_valid = 1'b0;
        tick();
        tick();
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mm", 32'(mismatch), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        rst = 1'b0;
        tick();

        // Window of 4: stream 1,0,0,0 yields 0x0008.
        open(8'd4, 16'h0008, 16'h0008, 1'b0);
        sample(1'b1, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b1);
        sample(1'b0, 1'b0, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sig_hold", 32'(sig), 32'h0008);

        // Window of 17 with matching golden: feedback fold on the last sample.
        open(8'd17, 16'h1021, 16'h1021, 1'b0);
        sample(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) sample(1'b0, 1'b1, 1'b0);
        chk("sig_16", 32'(sig), 32'h8000);
        sample(1'b0, 1'b1, 1'b1);

        // Same stream with wrong golden raises mismatch and alarm.
        open(8'd17, 16'h0000, 16'h1021, 1'b1);
        sample(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b1, i == 15);
        sample(1'b1, 1'b1, 1'b0);
        chk("mm_held", 32'(mismatch), 32'd1);
        chk("sig_held", 32'(sig), 32'h1021);

        // Matching window afterwards keeps alarm sticky.
        open(8'd4, 16'h0008, 16'h0008, 1'b1);
        sample(1'b1, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b0, 1'b1, 1'b1);

        // Gapped valids; a start mid-window must be ignored.
        open(8'd4, 16'h0000, 16'h0000, 1'b1);
        sample(1'b0, 1'b1, 1'b0);
        start = 1'b1; win_len = 8'd1; golden_sig = 16'hffff;
        sample(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        chk("mid_start_busy", 32'(busy), 32'd1);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b1, 1'b0);
        sample(1'b1, 1'b0, 1'b0);
        sample(1'b0, 1'b1, 1'b1);

        // Start in the DONE cycle, then reset aborts after two samples.
        open(8'd4, 16'h0000, 16'h0000, 1'b1);
        sample(1'b1, 1'b1, 1'b0);
        sample(1'b1, 1'b1, 1'b0);
        chk("pre_rst_sig", 32'(sig), 32'h0003);
        rst = 1'b1; start = 1'b1; resp_valid = 1'b1; resp_in = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_in = 1'b0;
        sb.delete(sb.size() - 1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sig", 32'(sig), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_alarm", 32'(alarm), 32'd0);
        sample(1'b1, 1'b1, 1'b0);
        sample(1'b1, 1'b1, 1'b0);
        chk("after_abort_sig", 32'(sig), 32'd0);

        // win_len=0 means a full 256-sample window.
        exp_s = 16'h0;
        for (int i = 0; i < 256; i++) begin
            bits[i] = 1'($urandom_range(0, 1));
            exp_s   = misr_m(exp_s, bits[i]);
        end
        open(8'd0, exp_s, exp_s, 1'b0);
        for (int i = 0; i < 256; i++) sample(bits[i], 1'b1, i == 255);
        sample(1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nt_resp_compactor.md
NT_RESP_COMPACTOR -- requirements
Module: nt_resp_compactor

Interface
REQ-001 The block SHALL have parameter SIG_W, default 16, signature width.
REQ-002 The block SHALL have parameter POLY, default 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1).
REQ-003 The block SHALL have parameter CNT_W, default 9, sample counter width (window up to 256).
REQ-004 The block SHALL have port I1470_clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have port I1477_rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start  input  1  single-cycle request to open a compaction window.
REQ-007 The block SHALL have port win_len  input  8  samples per window, sampled with start; 0 means 256.
REQ-008 The block SHALL have port golden_sig  input  SIG_W  expected signature, sampled with start.
REQ-009 The block SHALL have port resp_in  input  1  registered node output of the upstream Nt-node subcircuit.
REQ-010 The block SHALL have port resp_valid  input  1  resp_in is a valid sample this cycle.
REQ-011 The block SHALL have port sig  output  SIG_W  current/final signature.
REQ-012 The block SHALL have port busy  output  1  high while in RUN.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse, window complete.
REQ-014 The block SHALL have port mismatch  output  1  final sig != golden_sig, valid when done=1, held until next start.
REQ-015 The block SHALL have port alarm  output  1  sticky OR of all mismatches, cleared only by reset.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; busy=(state==RUN), done=(state==DONE).
REQ-017 In IDLE or DONE, start=1 SHALL latch win_len and golden_sig, clear sig and count to 0, clear mismatch, and enter RUN next edge.
REQ-018 start SHALL be ignored while in RUN.
REQ-019 In RUN, each cycle with resp_valid=1 SHALL update sig to ({sig[SIG_W-2:0],0} XOR (sig[SIG_W-1] ? POLY : 0) XOR {0..0,resp_in}) and increment count.
REQ-020 Cycles with resp_valid=0 SHALL leave sig and count unchanged; no timeout.
REQ-021 When the accepted sample makes count equal the window length (256 if latched win_len=0), the FSM SHALL enter DONE at that same edge.
REQ-022 At the edge entering DONE, mismatch SHALL be registered as (next sig != latched golden_sig) and alarm SHALL be set if mismatch is set.
REQ-023 DONE SHALL last exactly one cycle, then return to IDLE unless start=1 (REQ-017).
REQ-024 sig SHALL hold its final value in DONE and IDLE until the next start.
REQ-025 Latency: done SHALL be high in the cycle immediately after the cycle whose resp_valid sample completed the window.
REQ-026 resp_valid and resp_in SHALL be ignored in IDLE and DONE.

Reset
REQ-027 I1477_rst=1 at a rising edge SHALL force state=IDLE, sig=0, count=0, busy=0, done=0, mismatch=0, alarm=0, latched win_len=0, latched golden_sig=0.
REQ-028 Reset SHALL take priority over start and resp_valid in the same cycle, and SHALL abort a window in progress with no done pulse.

Structure
REQ-029 Package nt_resp_pkg SHALL hold SIG_W, POLY, CNT_W defaults and the state enum (IDLE, RUN, DONE).
REQ-030 The MISR next-value function SHALL be a sub-module nt_misr_step (combinational, inputs sig and resp_in, output next sig).

Verification
REQ-031 start, win_len=4, resp stream 1,0,0,0 all valid -> done on 5th cycle after RUN entry edge, sig=16'h0008.
REQ-032 start, win_len=17, resp 1 then 16 zeros -> sig after 16 samples 16'h8000, final sig=16'h1021, golden_sig=16'h1021 -> mismatch=0, alarm=0.
REQ-033 Same as REQ-032 with golden_sig=16'h0000 -> mismatch=1 with done, alarm=1 and stays 1 through a later matching window.
REQ-034 win_len=4 with resp_valid gaps (1,0,1,0,1,0,1) all resp_in=0 -> done exactly one cycle after 4th valid, sig=16'h0000; start asserted mid-RUN ignored.
REQ-035 Reset asserted after 2 of 4 samples -> next cycle busy=0, sig=0, no done pulse; win_len=0 window then completes after 256 valid samples.
